uart_transmitter: RTL and testbench

//  Serialises one byte per handshake onto a UART line: start(0), 8 data bits LSB first,

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_transmitter.sv | 118 +++++++++++
 tb/tb_uart_transmitter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, state encoding and parity helper
// Purpose: one home for the frame format so transmitter and receiver agree on it.
// Contents: state constants, uart_tx_state_t, UART_DATA_BITS, UART_FRAME_BITS,
//           even_parity().
package uart_pkg;

   // Raw codes kept as plain constants so older code comparing against
   // numeric state values keeps working; the enum is built on top of them.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } uart_tx_state_t;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 11;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing a tick on the last cycle of each bit
// Purpose: counts 0..CYCLES_PER_BIT-1 and flags the final cycle of every line bit.
// Ports:
//   clk    in  clock
//   rst    in  asynchronous active-high reset
//   clear  in  hold the counter at 0 (next bit starts counting from 0)
//   tick   out high on the last cycle of the current bit
module uart_baud_gen #(
   parameter int CYCLES_PER_BIT = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmitter: start, 8 data bits LSB first, even parity, stop
// Purpose: accepts one byte per valid/ready handshake and serialises it onto tx.
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   enable    in   0 aborts any frame, holds the line idle, refuses data
//   tx_data   in   byte to send, sampled on accept
//   tx_valid  in   upstream offers tx_data
//   tx_ready  out  block can accept (accept = tx_valid & tx_ready at posedge)
//   tx        out  registered serial line, idle high
//   busy      out  frame in progress
//   done      out  one-cycle pulse on the last cycle of the stop bit
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ     = 50000000,
   parameter int BAUD_RATE      = 9600,
   parameter int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   uart_tx_state_t              state;
   logic [UART_DATA_BITS:0]     shift;   // {parity, data}; bit 0 is on the line in DATA
   logic [2:0]                  bit_cnt;
   logic                        tick;
   logic                        baud_clear;
   logic                        accept;

   // Counter sits at 0 while idle or disabled, so every state entry starts a
   // fresh bit; inside a frame it wraps on its own at each tick.
   assign baud_clear = (state == IDLE) || !enable;

   uart_baud_gen #(
      .CYCLES_PER_BIT (CYCLES_PER_BIT)
   ) u_baud_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (baud_clear),
      .tick  (tick)
   );

   assign tx_ready = enable && (state == IDLE);
   assign accept   = tx_valid && tx_ready;
   assign busy     = (state != IDLE);
   assign done     = (state == STOP) && tick && enable;

   // tx is loaded with the value of the bit being entered, so the line
   // changes on the same edge as the state and never glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tx      <= 1'b1;
         shift   <= '0;
         bit_cnt <= '0;
      end else if (!enable) begin
         state   <= IDLE;
         tx      <= 1'b1;
         bit_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (accept) begin
                  shift <= {even_parity(tx_data), tx_data};
                  state <= START;
                  tx    <= 1'b0;
               end
            end
            START: begin
               if (tick) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  tx      <= shift[0];
               end
            end
            DATA: begin
               if (tick) begin
                  // shift[1] is the next data bit, or the parity bit after bit 7
                  shift   <= {1'b0, shift[UART_DATA_BITS:1]};
                  tx      <= shift[1];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == LAST_BIT) begin
                     state <= PARITY;
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
            end
            STOP: begin
               if (tick) begin
                  state <= IDLE;
                  tx    <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed self-checking bench for uart_transmitter
module tb_uart_transmitter;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       busy;
   logic       done;

   logic       enable2;
   logic [7:0] tx_data2;
   logic       tx_valid2;
   logic       tx_ready2;
   logic       tx2;
   logic       busy2;
   logic       done2;

   int vectors = 0;
   int miscompares = 0;

   uart_transmitter #(.CLOCK_FREQ(100), .BAUD_RATE(10)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .busy     (busy),
      .done     (done)
   );

   uart_transmitter #(.CLOCK_FREQ(160), .BAUD_RATE(10)) dut16 (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable2),
      .tx_data  (tx_data2),
      .tx_valid (tx_valid2),
      .tx_ready (tx_ready2),
      .tx       (tx2),
      .busy     (busy2),
      .done     (done2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Caller has tx_valid high at a negedge; the next posedge accepts, and
   // iteration k samples the k-th cycle after the accepting edge.
   // f: {stop, parity, data[7:0], start}, written out by hand per byte.
   task automatic check_frame(input logic [10:0] f, input logic hold_valid,
                              input logic [7:0] next_data, input string tag);
      for (int k = 0; k < 110; k++) begin
         @(negedge clk);
         if (k == 0) begin
            check({tag, " ready_low"}, 32'(tx_ready), 32'd0);
            check({tag, " busy"}, 32'(busy), 32'd1);
            tx_valid = hold_valid;
            tx_data  = next_data;
         end
         check($sformatf("%s tx c%0d", tag, k), 32'(tx), 32'(f[k / 10]));
         check($sformatf("%s done c%0d", tag, k), 32'(done), (k == 109) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      check({tag, " idle tx"}, 32'(tx), 32'd1);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      check({tag, " idle ready"}, 32'(tx_ready), 32'd1);
      check({tag, " idle done"}, 32'(done), 32'd0);
   endtask

   initial begin
      int         done_cnt;
      int         low_cnt;
      logic       found;
      logic [7:0] rx_byte;
      logic       rx_par;
      logic       rx_stop;

      rst = 1'b1; enable = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
      enable2 = 1'b1; tx_valid2 = 1'b0; tx_data2 = 8'h00;

      // reset state
      @(negedge clk);
      check("rst tx", 32'(tx), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst ready", 32'(tx_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // 0xA5: bits 1,0,1,0,0,1,0,1, parity 0
      tx_data = 8'hA5; tx_valid = 1'b1;
      check("a5 ready", 32'(tx_ready), 32'd1);
      check_frame(11'b1_0_10100101_0, 1'b0, 8'h5A, "a5");
      check_idle("a5");

      // parity cases
      tx_data = 8'h07; tx_valid = 1'b1;
      check_frame(11'b1_1_00000111_0, 1'b0, 8'hF8, "07");
      check_idle("07");
      tx_data = 8'hFF; tx_valid = 1'b1;
      check_frame(11'b1_0_11111111_0, 1'b0, 8'h00, "ff");
      check_idle("ff");

      // back-to-back with tx_valid held; data changes mid-frame
      tx_data = 8'h12; tx_valid = 1'b1;
      check_frame(11'b1_0_00010010_0, 1'b1, 8'h34, "12");
      check_idle("b2b gap");
      check_frame(11'b1_1_00110100_0, 1'b0, 8'h99, "34");
      check_idle("34");

      // reset during DATA bit 4 of 0xEF (bit 4 = 0)
      tx_data = 8'hEF; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (54) @(negedge clk);
      check("ef bit4", 32'(tx), 32'd0);
      rst = 1'b1;
      #1;
      check("midrst tx", 32'(tx), 32'd1);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      done_cnt = 0; low_cnt = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("post rst ready", 32'(tx_ready), 32'd1);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (!tx) low_cnt++;
      end
      check("midrst no done", 32'(done_cnt), 32'd0);
      check("midrst line idle", 32'(low_cnt), 32'd0);

      // enable dropped during PARITY of 0xA5 (parity 0)
      tx_data = 8'hA5; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (94) @(negedge clk);
      check("a5 parity", 32'(tx), 32'd0);
      check("a5 parity busy", 32'(busy), 32'd1);
      enable = 1'b0;
      #1;
      check("dis ready comb", 32'(tx_ready), 32'd0);
      @(negedge clk);
      check("dis tx", 32'(tx), 32'd1);
      check("dis busy", 32'(busy), 32'd0);
      check("dis done", 32'(done), 32'd0);
      check("dis ready", 32'(tx_ready), 32'd0);
      tx_data = 8'h00; tx_valid = 1'b1;
      repeat (5) @(negedge clk);
      check("dis refuse busy", 32'(busy), 32'd0);
      check("dis refuse tx", 32'(tx), 32'd1);
      check("dis refuse ready", 32'(tx_ready), 32'd0);
      enable = 1'b1;
      #1;
      check("en ready", 32'(tx_ready), 32'd1);
      check_frame(11'b1_0_00000000_0, 1'b0, 8'hFF, "00");
      check_idle("00");

      // 16 cycles per bit: decode the line at bit centres
      tx_data2 = 8'h3C; tx_valid2 = 1'b1;
      check("x16 ready", 32'(tx_ready2), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         tx_valid2 = 1'b0;
         if (!tx2) found = 1'b1;
      end
      check("x16 start seen", 32'(found), 32'd1);
      repeat (8) @(negedge clk);
      check("x16 start mid", 32'(tx2), 32'd0);
      rx_byte = 8'h00;
      for (int b = 0; b < 8; b++) begin
         repeat (16) @(negedge clk);
         rx_byte[b] = tx2;
      end
      repeat (16) @(negedge clk);
      rx_par = tx2;
      repeat (16) @(negedge clk);
      rx_stop = tx2;
      check("x16 data", 32'(rx_byte), 32'h3C);
      check("x16 parity", 32'(rx_par), 32'd0);
      check("x16 stop", 32'(rx_stop), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
